// File: rtl/datapath_pkg.sv
// Shared width, ALU opcode and bus-source encodings for the single-bus datapath.
// The bus-source code equals the strobe bit position, so lower codes win the bus.
package datapath_pkg;

    localparam int DATA_W  = 32;
    localparam int NUM_REG = 16;
    localparam int NUM_SRC = 23;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Codes 0..15 select R0..R15.
    localparam logic [4:0] SRC_HI     = 5'd16;
    localparam logic [4:0] SRC_LO     = 5'd17;
    localparam logic [4:0] SRC_ZHI    = 5'd18;
    localparam logic [4:0] SRC_ZLO    = 5'd19;
    localparam logic [4:0] SRC_PC     = 5'd20;
    localparam logic [4:0] SRC_MDR    = 5'd21;
    localparam logic [4:0] SRC_INPORT = 5'd22;
    localparam logic [4:0] SRC_NONE   = 5'd23;

    function automatic logic [4:0] bus_sel(input logic [NUM_SRC-1:0] strobes);
        logic [4:0] sel;
        sel = SRC_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (strobes[i]) sel = 5'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational 64-bit-result ALU: A comes from Y, B from the bus.
// DATAPATH_MULDIV_EN enables the signed multiplier and divider; otherwise MUL/DIV yield 0.
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  logic [4:0]          i_opcode,
    output logic [2*DATA_W-1:0] o_result
);

    logic [4:0] w_shamt;
    logic [5:0] w_shinv;

    assign w_shamt = i_b[4:0];
    assign w_shinv = 6'd32 - {1'b0, w_shamt};

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0]   w_div_b;
    logic signed [DATA_W-1:0]   w_quot;
    logic signed [DATA_W-1:0]   w_rem;
    logic                       w_div_zero;
    logic                       w_div_ovf;

    assign w_prod = $signed({{DATA_W{i_a[DATA_W-1]}}, i_a}) *
                    $signed({{DATA_W{i_b[DATA_W-1]}}, i_b});

    // MIN/-1 divides by 1 instead: a/1 is already the wrapped quotient and the remainder is 0.
    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_a == {1'b1, {(DATA_W-1){1'b0}}}) && (i_b == '1);
    assign w_div_b    = (w_div_zero || w_div_ovf) ? DATA_W'(1) : $signed(i_b);
    assign w_quot     = $signed(i_a) / w_div_b;
    assign w_rem      = $signed(i_a) % w_div_b;
`endif

    always_comb begin
        o_result = '0;
        case (i_opcode)
            OP_ADD:  o_result[DATA_W-1:0] = i_a + i_b;
            OP_SUB:  o_result[DATA_W-1:0] = i_a - i_b;
            OP_AND:  o_result[DATA_W-1:0] = i_a & i_b;
            OP_OR:   o_result[DATA_W-1:0] = i_a | i_b;
            OP_SHR:  o_result[DATA_W-1:0] = i_a >> w_shamt;
            OP_SHRA: o_result[DATA_W-1:0] = $signed(i_a) >>> w_shamt;
            OP_SHL:  o_result[DATA_W-1:0] = i_a << w_shamt;
            OP_ROR:  o_result[DATA_W-1:0] = (i_a >> w_shamt) | (i_a << w_shinv);
            OP_ROL:  o_result[DATA_W-1:0] = (i_a << w_shamt) | (i_a >> w_shinv);
            OP_NEG:  o_result[DATA_W-1:0] = '0 - i_b;
            OP_NOT:  o_result[DATA_W-1:0] = ~i_b;
`ifdef DATAPATH_MULDIV_EN
            OP_MUL:  o_result = w_prod;
            OP_DIV:  o_result = w_div_zero ? '0 : {w_rem, w_quot};
`endif
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, PC/HI/LO/MAR/MDR/Y/Z/InPort and a priority bus mux.
// Build with DATAPATH_MULDIV_EN defined to include MUL/DIV in the ALU.
module datapath
    import datapath_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              R0in,  R1in,  R2in,  R3in,  R4in,  R5in,  R6in,  R7in,
    input  logic              R8in,  R9in,  R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic              PCin,
    input  logic              HIin,
    input  logic              LOin,
    input  logic              MARin,
    input  logic              Yin,
    input  logic              InPortIn,
    input  logic              Zin,
    input  logic              MDRin,
    input  logic              read,
    input  logic              incPC,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] Mdatain,
    input  logic [DATA_W-1:0] inport_data,
    input  logic              R0out, R1out, R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
    input  logic              R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic              PCout,
    input  logic              HIout,
    input  logic              LOout,
    input  logic              ZHighOut,
    input  logic              ZLowOut,
    input  logic              MDRout,
    input  logic              InPortOut,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] mar_out
);

    logic [DATA_W-1:0]   r_regs [NUM_REG];
    logic [DATA_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_mar;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_y;
    logic [2*DATA_W-1:0] r_z;
    logic [DATA_W-1:0]   r_inport;

    logic [NUM_REG-1:0]  w_rin;
    logic [NUM_REG-1:0]  w_rout;
    logic [NUM_SRC-1:0]  w_src;
    logic [4:0]          w_sel;
    logic [DATA_W-1:0]   w_bus;
    logic [2*DATA_W-1:0] w_alu_result;

    assign w_rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                     R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
    assign w_rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                     R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
    assign w_src  = {InPortOut, MDRout, PCout, ZLowOut, ZHighOut, LOout, HIout, w_rout};
    assign w_sel  = bus_sel(w_src);

    always_comb begin
        w_bus = '0;
        case (w_sel)
            SRC_HI:     w_bus = r_hi;
            SRC_LO:     w_bus = r_lo;
            SRC_ZHI:    w_bus = r_z[2*DATA_W-1:DATA_W];
            SRC_ZLO:    w_bus = r_z[DATA_W-1:0];
            SRC_PC:     w_bus = r_pc;
            SRC_MDR:    w_bus = r_mdr;
            SRC_INPORT: w_bus = r_inport;
            SRC_NONE:   w_bus = '0;
            default:    w_bus = r_regs[w_sel[3:0]];
        endcase
    end

    datapath_alu u_alu (
        .i_a      (r_y),
        .i_b      (w_bus),
        .i_opcode (opcode),
        .o_result (w_alu_result)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
            r_pc     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mar    <= '0;
            r_mdr    <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_inport <= '0;
        end else begin
            for (int i = 0; i < NUM_REG; i++) begin
                if (w_rin[i]) r_regs[i] <= w_bus;
            end
            if (incPC)         r_pc <= r_pc + DATA_W'(1);
            else if (PCin)     r_pc <= w_bus;
            if (HIin)          r_hi <= w_bus;
            if (LOin)          r_lo <= w_bus;
            if (MARin)         r_mar <= w_bus;
            if (Yin)           r_y <= w_bus;
            if (MDRin)         r_mdr <= read ? Mdatain : w_bus;
            if (Zin)           r_z <= w_alu_result;
            if (InPortIn)      r_inport <= inport_data;
        end
    end

    assign bus_out = w_bus;
    assign mar_out = r_mar;

endmodule

// File: tb/tb_datapath.sv
// Directed-vector bench for datapath; MUL/DIV expectations follow DATAPATH_MULDIV_EN.
module tb_datapath;

    logic        clock;
    logic        clear;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pc_in, hi_in, lo_in, mar_in, y_in, inport_in, z_in, mdr_in, rd, inc_pc;
    logic        pc_out, hi_out, lo_out, zh_out, zl_out, mdr_out, inport_out;
    logic [4:0]  opc;
    logic [31:0] mdatain;
    logic [31:0] inport_data;
    logic [31:0] bus_out;
    logic [31:0] mar_out;

    int n_vec  = 0;
    int n_miss = 0;

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
        .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
        .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
        .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
        .PCin(pc_in), .HIin(hi_in), .LOin(lo_in), .MARin(mar_in), .Yin(y_in),
        .InPortIn(inport_in), .Zin(z_in), .MDRin(mdr_in), .read(rd), .incPC(inc_pc),
        .opcode(opc), .Mdatain(mdatain), .inport_data(inport_data),
        .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
        .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
        .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
        .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
        .PCout(pc_out), .HIout(hi_out), .LOout(lo_out), .ZHighOut(zh_out),
        .ZLowOut(zl_out), .MDRout(mdr_out), .InPortOut(inport_out),
        .bus_out(bus_out), .mar_out(mar_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rin = '0; rout = '0;
        pc_in = 0; hi_in = 0; lo_in = 0; mar_in = 0; y_in = 0; inport_in = 0;
        z_in = 0; mdr_in = 0; rd = 0; inc_pc = 0;
        pc_out = 0; hi_out = 0; lo_out = 0; zh_out = 0; zl_out = 0; mdr_out = 0; inport_out = 0;
        opc = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic load_inport(input logic [31:0] v);
        inport_data = v; inport_in = 1; step();
    endtask

    task automatic load_reg(input int n, input logic [31:0] v);
        load_inport(v);
        inport_out = 1; rin[n] = 1; step();
    endtask

    task automatic load_pc(input logic [31:0] v);
        load_inport(v);
        inport_out = 1; pc_in = 1; step();
    endtask

    task automatic read_reg(input string tag, input int n, input logic [31:0] exp);
        rout[n] = 1; #1;
        chk(tag, {32'h0, bus_out}, {32'h0, exp});
        rout[n] = 0;
    endtask

    task automatic read_z(output logic [63:0] z);
        zh_out = 1; #1; z[63:32] = bus_out; zh_out = 0;
        zl_out = 1; #1; z[31:0]  = bus_out; zl_out = 0;
    endtask

    task automatic alu_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [63:0] exp);
        logic [63:0] z;
        load_inport(a);
        inport_out = 1; y_in = 1; step();
        load_inport(b);
        inport_out = 1; opc = op; z_in = 1; step();
        read_z(z);
        chk(tag, z, exp);
    endtask

    logic [63:0] z_obs;
    logic [63:0] exp_mul, exp_div, exp_div_neg, exp_div_ovf, exp_mul_min;

    initial begin
`ifdef DATAPATH_MULDIV_EN
        exp_mul     = 64'hFFFFFFFF_FFFFFFD6;
        exp_div     = 64'h00000002_00000003;
        exp_div_neg = 64'hFFFFFFFE_FFFFFFFD;
        exp_div_ovf = 64'h00000000_80000000;
        exp_mul_min = 64'h40000000_00000000;
`else
        exp_mul     = 64'h0;
        exp_div     = 64'h0;
        exp_div_neg = 64'h0;
        exp_div_ovf = 64'h0;
        exp_mul_min = 64'h0;
`endif
        idle();
        mdatain = '0;
        inport_data = '0;
        clear = 0;
        #3;
        chk("rst_bus_idle", {32'h0, bus_out}, 64'h0);
        chk("rst_mar", {32'h0, mar_out}, 64'h0);
        pc_out = 1; #1;
        chk("rst_pc", {32'h0, bus_out}, 64'h0);
        pc_out = 0;
        @(negedge clock);
        clear = 1;

        // Populate state, then reset asynchronously between edges.
        load_reg(1, 32'h55);
        load_reg(15, 32'h77);
        load_pc(32'h33);
        inport_out = 1; mar_in = 1; step();
        read_reg("pre_clr_r1", 1, 32'h55);
        chk("pre_clr_mar", {32'h0, mar_out}, 64'h33);
        clear = 0; #2;
        chk("clr_mar", {32'h0, mar_out}, 64'h0);
        read_reg("clr_r1", 1, 32'h0);
        read_reg("clr_r15", 15, 32'h0);
        pc_out = 1; #1; chk("clr_pc", {32'h0, bus_out}, 64'h0); pc_out = 0;
        inport_out = 1; #1; chk("clr_inport", {32'h0, bus_out}, 64'h0); inport_out = 0;
        clear = 1;

        mdatain = 32'h0000000A; rd = 1; mdr_in = 1; step();
        mdr_out = 1; rin[0] = 1; #1;
        chk("mdr_to_bus", {32'h0, bus_out}, 64'hA);
        step();
        read_reg("r0_load", 0, 32'hA);

        rout[0] = 1; opc = OP_NOT_C(); z_in = 1; step();
        zl_out = 1; rin[5] = 1; #1;
        chk("not_zlo", {32'h0, bus_out}, 64'hFFFFFFF5);
        step();
        read_reg("not_r5", 5, 32'hFFFFFFF5);
        zh_out = 1; #1; chk("not_zhi", {32'h0, bus_out}, 64'h0); zh_out = 0;

        load_pc(32'd5);
        pc_out = 1; mar_in = 1; inc_pc = 1; step();
        chk("fetch_mar", {32'h0, mar_out}, 64'd5);
        pc_out = 1; #1; chk("fetch_pc_inc", {32'h0, bus_out}, 64'd6); pc_out = 0;
        mdatain = 32'h12; rd = 1; mdr_in = 1; step();
        mdr_out = 1; #1; chk("fetch_mdr", {32'h0, bus_out}, 64'h12); mdr_out = 0;
        load_pc(32'hFFFFFFFF);
        inc_pc = 1; step();
        pc_out = 1; #1; chk("pc_wrap", {32'h0, bus_out}, 64'h0); pc_out = 0;
        load_inport(32'h100);
        inport_out = 1; pc_in = 1; inc_pc = 1; step();
        pc_out = 1; #1; chk("incpc_prio", {32'h0, bus_out}, 64'h1); pc_out = 0;

        // MDR from the bus when read is low, then old-value-on-bus during a write.
        mdatain = 32'hDEAD; rd = 0; rout[0] = 1; mdr_in = 1; step();
        mdr_out = 1; #1; chk("mdr_from_bus", {32'h0, bus_out}, 64'hA); mdr_out = 0;
        mdatain = 32'h99; rd = 1; mdr_in = 1; mdr_out = 1; #1;
        chk("mdr_rw_old", {32'h0, bus_out}, 64'hA);
        step();
        mdr_out = 1; #1; chk("mdr_rw_new", {32'h0, bus_out}, 64'h99); mdr_out = 0;

        load_reg(6, 32'd30);
        load_reg(7, 32'd25);
        rout[6] = 1; y_in = 1; step();
        rout[7] = 1; opc = 5'b00011; z_in = 1; step();
        read_z(z_obs); chk("add_r6_r7", z_obs, 64'd55);
        rout[7] = 1; opc = 5'b00100; z_in = 1; step();
        read_z(z_obs); chk("sub_r6_r7", z_obs, 64'd5);

        alu_chk("shra",      32'h80000000, 32'd4,  5'b01000, 64'hF8000000);
        alu_chk("shr",       32'h80000000, 32'd4,  5'b00111, 64'h08000000);
        alu_chk("rol",       32'h80000000, 32'd1,  5'b01011, 64'h00000001);
        alu_chk("ror",       32'h00000001, 32'd1,  5'b01010, 64'h80000000);
        alu_chk("ror_amt0",  32'h12345678, 32'd32, 5'b01010, 64'h12345678);
        alu_chk("shl",       32'h00000003, 32'd31, 5'b01001, 64'h80000000);
        alu_chk("and",       32'hF0F01234, 32'h0FF0FF00, 5'b00101, 64'h00F01200);
        alu_chk("or",        32'hF0F01234, 32'h0FF0FF00, 5'b00110, 64'hFFF0FF34);
        alu_chk("add_wrap",  32'hFFFFFFFF, 32'd2,  5'b00011, 64'h1);
        alu_chk("sub_neg",   32'd3,        32'd5,  5'b00100, 64'hFFFFFFFE);
        alu_chk("neg",       32'd9,        32'd5,  5'b10001, 64'hFFFFFFFB);
        alu_chk("unused_op", 32'd5,        32'd6,  5'b11010, 64'h0);

        alu_chk("mul",       32'hFFFFFFFA, 32'd7,  5'b01111, exp_mul);
        zh_out = 1; hi_in = 1; step();
        zl_out = 1; lo_in = 1; step();
        hi_out = 1; #1; chk("mul_hi", {32'h0, bus_out}, {32'h0, exp_mul[63:32]}); hi_out = 0;
        lo_out = 1; #1; chk("mul_lo", {32'h0, bus_out}, {32'h0, exp_mul[31:0]}); lo_out = 0;
        alu_chk("mul_min",   32'h80000000, 32'h80000000, 5'b01111, exp_mul_min);
        alu_chk("div",       32'd17,       32'd5,  5'b10000, exp_div);
        alu_chk("div_neg",   32'hFFFFFFEF, 32'd5,  5'b10000, exp_div_neg);
        alu_chk("div_zero",  32'd17,       32'd0,  5'b10000, 64'h0);
        alu_chk("div_ovf",   32'h80000000, 32'hFFFFFFFF, 5'b10000, exp_div_ovf);

        load_reg(3, 32'd1);
        load_reg(9, 32'd2);
        rout[3] = 1; rout[9] = 1; #1;
        chk("prio_r3_r9", {32'h0, bus_out}, 64'h1);
        idle(); #1;
        chk("no_strobe", {32'h0, bus_out}, 64'h0);
        hi_out = 1; pc_out = 1; #1;
        chk("prio_hi_pc", {32'h0, bus_out}, {32'h0, exp_mul[63:32]});
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    function automatic logic [4:0] OP_NOT_C();
        return 5'b10010;
    endfunction

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus CPU datapath: register file R0–R15, PC, HI, LO, MAR, MDR, Y, 64-bit Z, input-port register and ALU, all sharing one bus.
- An external control sequencer drives one-hot in/out strobes and a 5-bit ALU opcode.
- Sits under the control unit; memory is modelled by the Mdatain input.

Parameters:
- DATA_W, 32, width of bus and all registers. Z is 2*DATA_W.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous active-low reset.
- R0in..R15in  in  1 each  load register Rn from bus.
- PCin, HIin, LOin, MARin, Yin, InPortIn  in  1 each  load named register. PC, HI, LO, MAR and Y load from bus; InPort loads from inport_data.
- Zin  in  1  load Z with the 64-bit ALU result.
- MDRin  in  1  load MDR from the MDR mux.
- read  in  1  MDR mux select: 1 = Mdatain, 0 = bus.
- incPC  in  1  PC <= PC + 1.
- opcode  in  5  ALU operation.
- Mdatain  in  32  memory read data.
- inport_data  in  32  external input-port data.
- R0out..R15out, PCout, HIout, LOout, ZHighOut, ZLowOut, MDRout, InPortOut  in  1 each  drive named source onto bus.
- bus_out  out  32  current bus value.
- mar_out  out  32  MAR contents (memory address).

Behaviour:
- Reset: clear=0 asynchronously zeroes R0–R15, PC, HI, LO, MAR, MDR, Y, Z and InPort. bus_out and mar_out are then 0.
- Bus: combinational fixed-priority mux with order R0..R15, HI, LO, ZHigh(Z[63:32]), ZLow(Z[31:0]), PC, MDR, InPort. If no out strobe is asserted, the bus is 0.
- Register loads take effect at the posedge with the enable high; otherwise the register holds. Same-cycle read and write of a register: the old value is on the bus, the new value is stored.
- PC: incPC has priority over PCin when both are asserted. PC increments with 32-bit wrap (0xFFFFFFFF -> 0).
- MDR: MDRin & read loads Mdatain; MDRin & !read loads the bus.
- ALU: A = Y, B = bus; result is 64 bits and is latched into Z only on Zin.
  - Logic, add/sub, shift and rotate ops: Z[31:0] = result, Z[63:32] = 0. Shift amount is B[4:0].
  - 00011 ADD: A+B, carry discarded.
  - 00100 SUB: A-B.
  - 00101 AND.
  - 00110 OR.
  - 00111 SHR: logical right.
  - 01000 SHRA: arithmetic right.
  - 01001 SHL.
  - 01010 ROR.
  - 01011 ROL.
  - 10001 NEG: 0-B.
  - 10010 NOT: ~B.
  - 01111 MUL: signed A*B, full 64 bits into Z.
  - 10000 DIV: signed; Z[31:0] = quotient, Z[63:32] = remainder. Divide by zero gives Z = 0.
  - All other codes (including 11010): result 0.
- Single-cycle latency for every ALU op.

Optional Feature:
- DATAPATH_MULDIV_EN.
  - Defined: MUL and DIV are implemented as above.
  - Undefined: MUL and DIV codes produce result 0 like other unused codes, and no multiplier/divider is synthesised.

Decomposition:
- datapath_pkg holds DATA_W, the opcode localparams (OP_ADD … OP_NOT) and the bus-source encoding.
- One sub-module, datapath_alu: combinational, inputs A, B, opcode; output 64-bit result. It contains the `ifdef for the mul/div feature.
- Registers and the bus mux stay in datapath.

Test Plan:
- Reset and load:
  - clear=0 mid-run -> all registers read 0 via bus.
  - clear=1; Mdatain=0x0000000A, read=1, MDRin=1 for one edge; then MDRout=1, R0in=1 -> bus_out=0x0000000A, R0=0x0000000A.
- NOT: R0=0x0000000A; R0out, opcode=10010, Zin for one edge; then ZLowOut, R5in -> R5=0xFFFFFFF5, ZHighOut drives 0.
- Fetch: PC=5; PCout, MARin, incPC for one edge -> mar_out=5, PC=6. Then read, MDRin with Mdatain=0x12 -> MDR=0x12. PC=0xFFFFFFFF with incPC -> PC=0.
- ADD/SUB/shift: Y=30 via R6out/Yin, R7=25 on bus.
  - ADD -> Z low 55.
  - SUB -> 5.
  - Y=0x80000000, B=4, SHRA -> 0xF8000000; SHR -> 0x08000000; ROL with B=1 -> 0x00000001.
- MUL/DIV (DATAPATH_MULDIV_EN defined):
  - Y=-6, B=7 MUL -> HI:LO via ZHigh/ZLow = 0xFFFFFFFF:0xFFFFFFD6.
  - Y=17, B=5 DIV -> LO=3, HI=2.
  - B=0 DIV -> Z=0.
  - Rerun without the macro -> Z=0 for both ops.
- Bus priority: R3out and R9out both asserted, R3=1, R9=2 -> bus_out=1. No out strobe -> bus_out=0.
